// File: rtl/mux_pkg.sv
// Shared definitions for the mux/arbiter family.
package mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } mux_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_nx1_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr,
// wrapping N-1 -> 0.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SELW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx,
  output logic            any_grant
);

  int j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!any_grant && req[j]) begin
        any_grant = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = SELW'(j);
      end
    end
  end

endmodule

// File: rtl/mux_arb_nx1.sv
// N-input arbitrating mux with packet lock and a registered
// valid/ready output stage.
module mux_arb_nx1
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N = 4,
  localparam int SELW = (clog2(N) < 1) ? 1 : clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  output logic [N-1:0]     in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]     in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [SELW-1:0]  out_sel,
  output logic             out_last
);

  mux_state_e      state;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] owner;

  logic [N-1:0]    rr_grant;
  logic [SELW-1:0] rr_idx;
  logic            rr_any;

  logic [N-1:0]    lock_grant;
  logic [N-1:0]    grant;
  logic [SELW-1:0] g;
  logic            load;
  logic            accept;
  logic            g_last;
  logic [SELW-1:0] ptr_nxt;

  rr_arbiter #(.N(N)) u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any_grant (rr_any)
  );

  always_comb begin
    lock_grant = '0;
    for (int i = 0; i < N; i++)
      lock_grant[i] = (owner == SELW'(i));
  end

  assign load = !out_valid || out_ready;

  always_comb begin
    grant = '0;
    g     = '0;
    unique case (1'b1)
      (state == ST_LOCK): begin
        grant = lock_grant;
        g     = owner;
      end
      default: begin
        grant = rr_any ? rr_grant : '0;
        g     = rr_idx;
      end
    endcase
  end

  // Reset gating keeps producers from seeing a ready during reset.
  assign in_ready = grant & {N{load}} & {N{rst_n}};
  assign accept   = |(in_valid & in_ready);
  assign g_last   = in_last[g];
  assign ptr_nxt  = (int'(g) == N - 1) ? '0 : g + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      owner     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[g*WIDTH +: WIDTH];
      out_sel   <= g;
      out_last  <= g_last;
      if (g_last) begin
        state <= ST_IDLE;
        ptr   <= ptr_nxt;
      end else begin
        state <= ST_LOCK;
        owner <= g;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1 (N=4, WIDTH=32).
module tb_mux_arb_nx1;

  localparam int W = 32;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_last;

  int n_cmp;
  int n_err;

  mux_arb_nx1 #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v,
                         input logic [1:0] s, input logic l);
    logic [W-1:0] d;
    d = 32'h11111111 * (s + 1);
    chk({tag, ".valid"}, out_valid, v);
    chk({tag, ".sel"}, out_sel, s);
    chk({tag, ".data"}, out_data, d);
    chk({tag, ".last"}, out_last, l);
  endtask

  logic [1:0] rr_exp [5];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rr_exp[0] = 2'd1;
    rr_exp[1] = 2'd2;
    rr_exp[2] = 2'd3;
    rr_exp[3] = 2'd0;
    rr_exp[4] = 2'd1;
    for (int i = 0; i < N; i++)
      in_data[i*W +: W] = 32'h11111111 * (i + 1);

    // Reset with every input active
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b1;
    #2;
    chk("rst.in_ready", in_ready, 4'b0000);
    tick();
    tick();
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.data", out_data, 32'h0);
    chk("rst.sel", out_sel, 2'd0);
    chk("rst.last", out_last, 1'b0);
    chk("rst.in_ready2", in_ready, 4'b0000);

    // First beat after release
    rst_n    = 1'b1;
    in_valid = 4'b0001;
    #1;
    chk("first.in_ready", in_ready, 4'b0001);
    tick();
    chk_out("first", 1'b1, 2'd0, 1'b1);

    // Round robin, ptr now 1
    in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out($sformatf("rr%0d", i), 1'b1, rr_exp[i], 1'b1);
    end

    // Lock on channel 1 for three beats
    in_valid = 4'b0010;
    in_last  = 4'b1101;
    #1;
    chk("lock.ready0", in_ready, 4'b0010);
    tick();
    chk_out("lock.b0", 1'b1, 2'd1, 1'b0);
    in_valid = 4'b0111;
    #1;
    chk("lock.ready1", in_ready, 4'b0010);
    tick();
    chk_out("lock.b1", 1'b1, 2'd1, 1'b0);
    in_last = 4'b1111;
    #1;
    chk("lock.ready2", in_ready, 4'b0010);
    tick();
    chk_out("lock.b2", 1'b1, 2'd1, 1'b1);
    in_valid = 4'b0101;
    tick();
    chk_out("lock.next", 1'b1, 2'd2, 1'b1);

    // Backpressure, ptr now 3
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp.ready%0d", i), in_ready, 4'b0000);
      tick();
      chk_out($sformatf("bp%0d", i), 1'b1, 2'd2, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", in_ready, 4'b1000);
    tick();
    chk_out("bp.release", 1'b1, 2'd3, 1'b1);

    // Lock bubble on owner 2, ptr now 0
    in_valid = 4'b0100;
    in_last  = 4'b1011;
    tick();
    chk_out("bub.b0", 1'b1, 2'd2, 1'b0);
    in_valid = 4'b1011;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("bub.others%0d", i), in_ready & 4'b1011, 4'b0000);
      tick();
      chk($sformatf("bub.valid%0d", i), out_valid, 1'b0);
      chk($sformatf("bub.sel%0d", i), out_sel, 2'd2);
    end
    in_valid = 4'b1111;
    tick();
    chk_out("bub.b1", 1'b1, 2'd2, 1'b0);
    in_last = 4'b1111;
    tick();
    chk_out("bub.b2", 1'b1, 2'd2, 1'b1);

    // Async reset mid-packet on channel 3 (ptr now 3)
    in_valid = 4'b1000;
    in_last  = 4'b0111;
    tick();
    chk_out("ar.b0", 1'b1, 2'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.valid", out_valid, 1'b0);
    chk("ar.data", out_data, 32'h0);
    chk("ar.sel", out_sel, 2'd0);
    chk("ar.in_ready", in_ready, 4'b0000);
    tick();
    rst_n    = 1'b1;
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    #1;
    chk("ar.ready_after", in_ready, 4'b0001);
    tick();
    chk_out("ar.n0", 1'b1, 2'd0, 1'b1);
    tick();
    chk_out("ar.n1", 1'b1, 2'd1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_arb_nx1.md
# mux_arb_nx1

Parametrised N-input, WIDTH-bit arbitrating multiplexer with a registered output. It generalises the combinational 2x1 32-bit mux to N channels. A round-robin arbiter replaces the external select, with valid/ready handshakes on every input and on the output. Packet locking holds a grant across multi-beat transfers. It sits between multiple producers (for example load/store and fetch result paths) and a single consumer port in the datapath.

## Interface
Parameters:
- WIDTH, 32, data width per channel.
- N, 4, number of input channels (N >= 1).
- SELW, derived localparam = max(1, clog2(N)), width of the channel index.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  N  per-channel data valid.
- in_ready  out  N  per-channel accept. Bit i is high only when channel i is granted and the output register can load.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  in  N  final beat of a packet on channel i.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  WIDTH  registered data.
- out_sel  out  SELW  index of the channel that supplied out_data.
- out_last  out  1  registered copy of in_last for the beat.

## Operation
- State machine with two states:
  - IDLE: the grant is picked round-robin among asserted in_valid bits. Search starts at pointer ptr and wraps N-1 -> 0.
  - LOCK: the grant is fixed to register owner, regardless of other valid bits.
- load = !out_valid || out_ready. in_ready = onehot(grant) & {N{load}}.
- Accept on channel g means in_valid[g] && in_ready[g]. On accept:
  - out_data <= in_data[g], out_sel <= g, out_last <= in_last[g], out_valid <= 1.
  - If in_last[g] is 0: state becomes LOCK and owner <= g.
  - If in_last[g] is 1: state becomes IDLE and ptr <= (g+1) mod N.
- If out_ready is high and nothing is accepted, out_valid <= 0. out_data, out_sel and out_last keep their old values.
- If out_valid && !out_ready: all outputs are held stable and in_ready is all zero.
- No valid input in IDLE: no grant, and ptr is unchanged.
- In LOCK with in_valid[owner] low: remain in LOCK. Other channels stay stalled, with no timeout.
- ptr advances only on an accepted last beat. Non-last beats never move it.
- N = 1: the arbiter degenerates to the single channel, and ptr is always 0.
- Reset mid-packet discards the lock and any held beat.

## Timing
- Reset values: out_valid 0, out_data 0, out_sel 0, out_last 0, ptr 0, owner 0, state IDLE. in_ready is 0 while rst_n is low.
- Latency: 1 cycle from accept to out_valid/out_data.
- Throughput: 1 beat per cycle while out_ready stays high, including back-to-back beats from different channels.
- in_ready depends combinationally on in_valid, state, ptr, out_valid and out_ready. No combinational path exists from in_data to any output.

## Structure
- Shared package mux_pkg:
  - state encodings ST_IDLE = 1'b0 and ST_LOCK = 1'b1.
  - clog2 helper function, reused by future mux/arbiter blocks.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], ptr[SELW].
  - outputs: onehot grant[N], encoded grant index, any_grant.
  - purely combinational.
- Top level holds the FSM, ptr/owner registers and the output register.

## Test plan
- Reset: hold rst_n low with all inputs active -> all outputs 0 and in_ready = 0. Release, drive in_valid = 4'b0001 with in_data[0] = 32'h11111111, last = 1 -> next cycle out_valid = 1, out_data = 32'h11111111, out_sel = 0.
- Round-robin: in_valid = 4'b1111, all last = 1, out_ready = 1 -> out_sel sequence 0,1,2,3,0. Wrap from 3 to 0 observed.
- Lock: channel 1 sends 3 beats (last on the 3rd) while channels 0 and 2 are valid -> out_sel = 1,1,1, then 2. in_ready[0] and in_ready[2] are 0 during the packet.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> out_data and out_sel stable, in_ready = 0. Release -> next beat loads on that same edge.
- Lock bubble: owner 2 drops in_valid mid-packet for 2 cycles -> out_valid falls to 0 and no other channel is granted. Resume -> beats continue from channel 2.
- Async reset mid-packet: assert rst_n low between clock edges during LOCK -> outputs clear immediately. After release, ptr = 0 and the next grant follows round-robin from channel 0.
